// File: rtl/game_session_ctrl.sv
// Session controller for a split-screen game: round FSM, rating, BCD MM:SS timer and pane mux.
// Define GAME_SESSION_COUNTDOWN_EN to insert a 3-second countdown between REGEN and RUNNING.
module game_session_ctrl #(
    parameter int          NUM_GAMES     = 2,
    parameter int          SCREEN_WIDTH  = 800,
    parameter int          RATING_WIDTH  = 8,
    parameter int          TICKS_PER_SEC = 25000000,
    parameter int unsigned WIN_MASK      = 1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      i_start,
    input  logic                      i_pause,
    input  logic [NUM_GAMES-1:0]      i_win,
    input  logic [NUM_GAMES-1:0]      i_lose,
    input  logic [NUM_GAMES-1:0]      i_ready,
    input  logic [10:0]               i_h_coord,
    input  logic [12*NUM_GAMES-1:0]   i_pane_rgb,
    input  logic [11:0]               i_banner_rgb,
    output logic                      o_regen,
    output logic                      o_running,
    output logic [1:0]                o_image,
    output logic [RATING_WIDTH-1:0]   o_rating,
    output logic [15:0]               o_timer,
    output logic [2*NUM_GAMES-1:0]    o_game_state,
    output logic [11:0]               o_rgb
);

    localparam logic [2:0] S_BANNER  = 3'd0;
    localparam logic [2:0] S_REGEN   = 3'd1;
    localparam logic [2:0] S_RUNNING = 3'd3;
    localparam logic [2:0] S_PAUSED  = 3'd4;
    localparam logic [2:0] S_WON     = 3'd5;
    localparam logic [2:0] S_LOST    = 3'd6;
`ifdef GAME_SESSION_COUNTDOWN_EN
    localparam logic [2:0] S_COUNTDOWN   = 3'd2;
    localparam logic [2:0] S_AFTER_REGEN = S_COUNTDOWN;
`else
    localparam logic [2:0] S_AFTER_REGEN = S_RUNNING;
`endif

    localparam logic [NUM_GAMES-1:0] WIN_MASK_V = WIN_MASK[NUM_GAMES-1:0];
    localparam int                   PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]        PRESC_MAX  = PW'(TICKS_PER_SEC - 1);

    logic [2:0]               state_q, state_d;
    logic                     start_q;
    logic                     start_edge;
    logic [PW-1:0]            presc_q, presc_d;
    logic [15:0]              timer_q, timer_d;
    logic [RATING_WIDTH-1:0]  rating_q, rating_d;
    logic [2*NUM_GAMES-1:0]   gstate_q, gstate_d;
    logic                     tick;
    logic                     run_entry;

    assign start_edge = i_start & ~start_q;
    assign tick       = (presc_q == PRESC_MAX);

    // Increment MM:SS in BCD; 59:59 rolls over to 00:00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd9) begin
            r[3:0] = t[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                r[7:4] = t[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    r[11:8] = t[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    r[15:12] = (t[15:12] != 4'd5) ? t[15:12] + 4'd1 : 4'd0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BANNER, S_WON, S_LOST: begin
                if (start_edge) state_d = S_REGEN;
            end
            S_REGEN: begin
                if (&i_ready) state_d = S_AFTER_REGEN;
            end
`ifdef GAME_SESSION_COUNTDOWN_EN
            S_COUNTDOWN: begin
                if (tick && timer_q == 16'h0001) state_d = S_RUNNING;
            end
`endif
            // Lose outranks win, and both outrank pause.
            S_RUNNING: begin
                if (|i_lose)                   state_d = S_LOST;
                else if (|(i_win & WIN_MASK_V)) state_d = S_WON;
                else if (i_pause)              state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (!i_pause) state_d = S_RUNNING;
            end
            default: state_d = S_BANNER;
        endcase
    end

`ifdef GAME_SESSION_COUNTDOWN_EN
    assign run_entry = (state_d == S_RUNNING) &&
                       ((state_q == S_REGEN) || (state_q == S_COUNTDOWN));
`else
    assign run_entry = (state_d == S_RUNNING) && (state_q == S_REGEN);
`endif

    always_comb begin
        presc_d  = presc_q;
        timer_d  = timer_q;
        rating_d = rating_q;
        gstate_d = gstate_q;

        if (run_entry) begin
            presc_d = '0;
            timer_d = 16'h0000;
`ifdef GAME_SESSION_COUNTDOWN_EN
        end else if (state_q == S_REGEN && state_d == S_COUNTDOWN) begin
            presc_d = '0;
            timer_d = 16'h0003;
        end else if (state_q == S_COUNTDOWN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) timer_d = timer_q - 16'h0001;
`endif
        end else if (state_q == S_RUNNING) begin
            // PAUSED leaves the prescaler untouched so a partial second survives a pause.
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) timer_d = bcd_inc(timer_q);
        end

        if (state_q == S_RUNNING && state_d == S_WON) begin
            rating_d = (rating_q == '1) ? rating_q : rating_q + RATING_WIDTH'(1);
            gstate_d = {i_win, i_lose};
        end else if (state_q == S_RUNNING && state_d == S_LOST) begin
            rating_d = '0;
            gstate_d = {{NUM_GAMES{1'b0}}, i_lose};
        end else if (state_q != S_REGEN && state_d == S_REGEN) begin
            gstate_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_BANNER;
            start_q  <= 1'b0;
            presc_q  <= '0;
            timer_q  <= 16'h0000;
            rating_q <= '0;
            gstate_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_start;
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            rating_q <= rating_d;
            gstate_q <= gstate_d;
        end
    end

    assign o_regen      = (state_q == S_REGEN);
    assign o_running    = (state_q == S_RUNNING);
    assign o_rating     = rating_q;
    assign o_timer      = timer_q;
    assign o_game_state = gstate_q;

    always_comb begin
        case (state_q)
            S_WON:    o_image = 2'd1;
            S_LOST:   o_image = 2'd2;
            S_PAUSED: o_image = 2'd3;
            default:  o_image = 2'd0;
        endcase
    end

    // Pane k covers columns where h*NUM_GAMES >= k*SCREEN_WIDTH; the top pane absorbs overscan.
    logic [31:0]          h_scaled;
    logic [NUM_GAMES-1:0] pane_ge;
    logic [11:0]          pane_rgb;

    assign h_scaled = 32'(i_h_coord) * 32'(NUM_GAMES);

    generate
        for (genvar gi = 0; gi < NUM_GAMES; gi++) begin : g_pane_cmp
            assign pane_ge[gi] = (h_scaled >= 32'(gi * SCREEN_WIDTH));
        end
    endgenerate

    always_comb begin
        pane_rgb = i_pane_rgb[11:0];
        for (int k = 0; k < NUM_GAMES; k++) begin
            if (pane_ge[k]) pane_rgb = i_pane_rgb[12*k +: 12];
        end
    end

    assign o_rgb = o_running ? pane_rgb : i_banner_rgb;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed bench for game_session_ctrl: 2 panes, 4 ticks per second, default (no countdown) build.
module tb_game_session_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        i_start;
    logic        i_pause;
    logic [1:0]  i_win;
    logic [1:0]  i_lose;
    logic [1:0]  i_ready;
    logic [10:0] i_h_coord;
    logic [23:0] i_pane_rgb;
    logic [11:0] i_banner_rgb;
    logic        o_regen;
    logic        o_running;
    logic [1:0]  o_image;
    logic [7:0]  o_rating;
    logic [15:0] o_timer;
    logic [3:0]  o_game_state;
    logic [11:0] o_rgb;

    int n_checks = 0;
    int n_fails  = 0;
    int regen_cnt;

    game_session_ctrl #(
        .NUM_GAMES    (2),
        .SCREEN_WIDTH (800),
        .RATING_WIDTH (8),
        .TICKS_PER_SEC(4),
        .WIN_MASK     (1)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_start     (i_start),
        .i_pause     (i_pause),
        .i_win       (i_win),
        .i_lose      (i_lose),
        .i_ready     (i_ready),
        .i_h_coord   (i_h_coord),
        .i_pane_rgb  (i_pane_rgb),
        .i_banner_rgb(i_banner_rgb),
        .o_regen     (o_regen),
        .o_running   (o_running),
        .o_image     (o_image),
        .o_rating    (o_rating),
        .o_timer     (o_timer),
        .o_game_state(o_game_state),
        .o_rgb       (o_rgb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From BANNER/WON/LOST: start edge -> REGEN -> RUNNING (i_ready must be all ones).
    task automatic new_round();
        i_start = 1'b0;
        step(1);
        i_start = 1'b1;
        step(1);
        step(1);
    endtask

    initial begin
        arst_n       = 1'b0;
        i_start      = 1'b0;
        i_pause      = 1'b0;
        i_win        = 2'b00;
        i_lose       = 2'b00;
        i_ready      = 2'b11;
        i_h_coord    = 11'd0;
        i_pane_rgb   = {12'hB2B, 12'hA1A};
        i_banner_rgb = 12'h5C5;

        #12;
        check_eq("rst_regen",   32'(o_regen), 0);
        check_eq("rst_running", 32'(o_running), 0);
        check_eq("rst_image",   32'(o_image), 0);
        check_eq("rst_rating",  32'(o_rating), 0);
        check_eq("rst_timer",   32'(o_timer), 0);
        check_eq("rst_gstate",  32'(o_game_state), 0);
        check_eq("rst_rgb",     32'(o_rgb), 32'h5C5);

        // Start held high for 10 cycles: one REGEN cycle, then RUNNING.
        step(1);
        arst_n  = 1'b1;
        i_start = 1'b1;
        regen_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (o_regen) regen_cnt++;
        end
        check_eq("hold_regen_cycles", 32'(regen_cnt), 1);
        check_eq("hold_running",      32'(o_running), 1);
        check_eq("hold_timer",        32'(o_timer), 32'h0002);

        i_start = 1'b0;
        step(1);
        i_start = 1'b1;
        step(1);
        check_eq("start_ignored_run",   32'(o_running), 1);
        check_eq("start_ignored_regen", 32'(o_regen), 0);

        i_h_coord = 11'd399;
        #1 check_eq("rgb_399", 32'(o_rgb), 32'hA1A);
        i_h_coord = 11'd400;
        #1 check_eq("rgb_400", 32'(o_rgb), 32'hB2B);
        i_h_coord = 11'd1023;
        #1 check_eq("rgb_1023", 32'(o_rgb), 32'hB2B);

        // Asynchronous reset in the middle of a round.
        #3 arst_n = 1'b0;
        i_start = 1'b0;
        #1;
        check_eq("midrst_running", 32'(o_running), 0);
        check_eq("midrst_timer",   32'(o_timer), 0);
        step(1);
        arst_n  = 1'b1;
        i_ready = 2'b01;
        step(2);
        check_eq("midrst_banner_regen", 32'(o_regen), 0);
        check_eq("midrst_banner_run",   32'(o_running), 0);
        check_eq("midrst_banner_img",   32'(o_image), 0);
        check_eq("banner_rgb",          32'(o_rgb), 32'h5C5);

        // REGEN waits for every ready bit.
        i_start = 1'b1;
        step(1);
        regen_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (o_regen) regen_cnt++;
            step(1);
        end
        if (o_regen) regen_cnt++;
        check_eq("regen_wait_not_run", 32'(o_running), 0);
        i_ready = 2'b11;
        step(1);
        check_eq("regen_cycles",   32'(regen_cnt), 6);
        check_eq("regen_exit_run", 32'(o_running), 1);
        check_eq("regen_exit_low", 32'(o_regen), 0);

        // Run 8, pause 20, run 4.
        step(8);
        check_eq("run8_timer", 32'(o_timer), 32'h0002);
        i_pause = 1'b1;
        step(1);
        check_eq("paused_image",   32'(o_image), 3);
        check_eq("paused_running", 32'(o_running), 0);
        step(18);
        i_win = 2'b01;
        step(1);
        i_win = 2'b00;
        check_eq("paused_win_ignored", 32'(o_image), 3);
        check_eq("paused_timer_held",  32'(o_timer), 32'h0002);
        i_pause = 1'b0;
        step(1);
        check_eq("resume_running", 32'(o_running), 1);
        step(4);
        check_eq("resume_timer", 32'(o_timer), 32'h0003);

        i_win = 2'b01;
        step(1);
        i_win = 2'b00;
        check_eq("won_image",  32'(o_image), 1);
        check_eq("won_rating", 32'(o_rating), 1);
        check_eq("won_gstate", 32'(o_game_state), 32'b0100);
        check_eq("won_timer",  32'(o_timer), 32'h0003);

        i_start = 1'b0;
        step(1);
        i_start = 1'b1;
        step(1);
        check_eq("regen_clr_gstate", 32'(o_game_state), 0);
        step(1);
        check_eq("round2_running", 32'(o_running), 1);

        // Simultaneous win and lose: lose takes priority.
        i_win  = 2'b01;
        i_lose = 2'b10;
        step(1);
        i_win  = 2'b00;
        i_lose = 2'b00;
        check_eq("lost_image",  32'(o_image), 2);
        check_eq("lost_rating", 32'(o_rating), 0);
        check_eq("lost_gstate", 32'(o_game_state), 32'b0010);
        i_win = 2'b01;
        step(1);
        i_win = 2'b00;
        check_eq("lost_win_ignored", 32'(o_image), 2);
        check_eq("lost_rating_held", 32'(o_rating), 0);

        // Pause and lose together end in LOST.
        new_round();
        i_pause = 1'b1;
        i_lose  = 2'b01;
        step(1);
        i_pause = 1'b0;
        i_lose  = 2'b00;
        check_eq("pause_lose_image",  32'(o_image), 2);
        check_eq("pause_lose_gstate", 32'(o_game_state), 32'b0001);

        // Long run through the BCD carries and the 59:59 wrap.
        new_round();
        check_eq("long_run_start", 32'(o_timer), 0);
        step(240);
        check_eq("timer_1min", 32'(o_timer), 32'h0100);
        step(14156);
        check_eq("timer_5959", 32'(o_timer), 32'h5959);
        step(4);
        check_eq("timer_wrap", 32'(o_timer), 32'h0000);

        // Rating saturation.
        arst_n = 1'b0;
        i_start = 1'b0;
        step(1);
        arst_n = 1'b1;
        for (int r = 0; r < 255; r++) begin
            new_round();
            i_win = 2'b01;
            step(1);
            i_win = 2'b00;
        end
        check_eq("rating_255", 32'(o_rating), 32'hFF);
        new_round();
        i_win = 2'b10;
        step(1);
        i_win = 2'b00;
        check_eq("unmasked_win_running", 32'(o_running), 1);
        check_eq("unmasked_win_rating",  32'(o_rating), 32'hFF);
        i_win = 2'b01;
        step(1);
        i_win = 2'b00;
        check_eq("sat_won_image", 32'(o_image), 1);
        check_eq("sat_rating",    32'(o_rating), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
